sram_bus_master: RTL
====================

# sram_bus_master

Upstream controller that turns single-beat CPU load/store requests into the cycle sequence the SRAM module (MAR/MDR + 2K×16 array) expects on its shared 16-bit mainBus. It registers each request, drives address, data, `wr` and `enableOutput` in a fixed multi-cycle order, and handles tristate ownership and write-to-read bus turnaround. It returns read data through a one-cycle response pulse. It sits between the CPU datapath/load-store stage and the SRAM module.

## Interface
- ADDR_W, 11, address width (matches mainBusAddr)
- DATA_W, 16, data width (matches mainBus)
- RD_WAIT, 1, extra read wait cycles after RD_SETUP (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept; transfer when req_valid & req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle pulse, load data valid
- rsp_rdata  out  DATA_W  load data, held until next load completes
- mainBus  inout  DATA_W  shared data bus to SRAM module
- mainBusAddr  out  ADDR_W  address to SRAM module
- wr  out  1  0 = write, 1 = read (SRAM module convention)
- enableOutput  out  1  SRAM output enable

## Operation
- States: IDLE, WR_SETUP, WR_COMMIT, TURN, RD_SETUP, RD_WAIT.
- Accept: in IDLE, req_ready=1. On the accept edge, latch req_we/addr/wdata into internal registers. Inputs are ignored outside the accept edge.
- IDLE: mainBus=Z, wr=1, enableOutput=0, mainBusAddr holds the last value.
- Store: IDLE→WR_SETUP→WR_COMMIT→IDLE. In both states: mainBusAddr=addr, mainBus driven with wdata, wr=0, enableOutput=0. A write_last flag is set.
- Load: IDLE→(TURN if write_last)→RD_SETUP→RD_WAIT×RD_WAIT→IDLE.
  - TURN: mainBus=Z, wr=1, enableOutput=0. Clears write_last.
  - RD_SETUP/RD_WAIT: mainBusAddr=addr, mainBus=Z, wr=1, enableOutput=1.
  - At the end of the last RD_WAIT cycle, capture mainBus into rsp_rdata. rsp_valid=1 in the following cycle, which is IDLE.
- The wait counter is RD_WAIT-wide enough, loads RD_WAIT-1 on entry to RD_WAIT, and exits at 0.
- The controller drives mainBus only in WR_SETUP/WR_COMMIT. It never drives mainBus while enableOutput=1.
- No response backpressure: the consumer must take rsp_valid when it occurs.
- Store-then-load to the same address returns the stored data.

## Timing
- Outputs are registered from state. A request accepted at edge E causes its first SRAM-side cycle right after E.
- Store: 2 busy cycles; req_ready=0 during both. The next accept is possible at the third edge after E.
- Load, no TURN: rsp_valid in cycle E+2+RD_WAIT (RD_WAIT=1 → 3 cycles after accept). Add 1 cycle if TURN is inserted.
- rsp_valid coincides with req_ready=1, so back-to-back loads overlap the response cycle with the next accept.
- Reset values (the cycle after reset is sampled high): state=IDLE, req_ready=0 while reset high, then 1. rsp_valid=0, rsp_rdata=0, mainBus=Z, mainBusAddr=0, wr=1, enableOutput=0, write_last=0.
- Reset mid-operation aborts on the same edge:
  - Bus released next cycle; no rsp_valid.
  - A store aborted in WR_SETUP/WR_COMMIT is undefined at the SRAM.
- req_valid high during busy states: ignored, no latch. The request must be held until req_ready.

## Test plan
- Reset: hold reset 3 cycles with req_valid=1 → all outputs at reset values, no accept, mainBus=Z throughout.
- Store 0x1234 → addr 0x005: exactly 2 cycles with wr=0, mainBusAddr=0x005, mainBus=0x1234. req_ready low those 2 cycles, then 1.
- Store 0xBEEF @0x7FF, then immediate load @0x7FF:
  - One TURN cycle with mainBus=Z, wr=1, enableOutput=0.
  - rsp_valid exactly 4 cycles after the load accept, rsp_rdata=0xBEEF.
- Back-to-back loads @0x000 then @0x001 (preloaded 0xAAAA/0x5555), RD_WAIT=1:
  - No TURN.
  - rsp_valid pulses 3 cycles after each accept, data in order.
  - Second accept lands in the first response cycle.
- RD_WAIT=3 build: load returns in E+5, enableOutput high for 4 consecutive cycles, no contention (controller never drives while enableOutput=1).
- Reset asserted in RD_WAIT: no rsp_valid, rsp_rdata=0, bus Z next cycle, a fresh load afterward completes normally.

Source files
------------

// File: rtl/sram_bus_master.sv
// sram_bus_master
//
// Turns single-beat CPU load/store requests into the fixed cycle sequence
// the MAR/MDR SRAM module expects on its shared 16-bit bus. A request is
// latched on the accept edge and the SRAM-side signals are then decoded
// from the registered state, so every bus phase lasts whole clock cycles.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid / req_ready    CPU request handshake (accept on valid & ready)
//   req_we                   1 = store, 0 = load
//   req_addr, req_wdata      word address and store data
//   rsp_valid                one-cycle pulse when load data is valid
//   rsp_rdata                load data, held until the next load completes
//   mainBus                  shared bidirectional data bus to the SRAM
//   mainBusAddr              address to the SRAM (holds last value in IDLE)
//   wr                       0 = write, 1 = read
//   enableOutput             SRAM output enable
module sram_bus_master #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    inout  wire  [DATA_W-1:0] mainBus,
    output logic [ADDR_W-1:0] mainBusAddr,
    output logic              wr,
    output logic              enableOutput
);

    // One bit minimum so RD_WAIT=1 still gets a legal counter.
    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_COMMIT = 3'd2,
        TURN      = 3'd3,
        RD_SETUP  = 3'd4,
        RD_WAIT_S = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                write_last_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                drive_bus;
    logic                accept;

    assign req_ready = (state_reg == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A load right after a store inserts one TURN cycle so
    // the write data driver is off the bus before the SRAM starts driving.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        state_next = WR_SETUP;
                    end else if (write_last_reg) begin
                        state_next = TURN;
                    end else begin
                        state_next = RD_SETUP;
                    end
                end
            end
            WR_SETUP:  state_next = WR_COMMIT;
            WR_COMMIT: state_next = IDLE;
            TURN:      state_next = RD_SETUP;
            RD_SETUP:  state_next = RD_WAIT_S;
            RD_WAIT_S: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        wr           = 1'b1;
        enableOutput = 1'b0;
        drive_bus    = 1'b0;
        case (state_reg)
            WR_SETUP, WR_COMMIT: begin
                wr        = 1'b0;
                drive_bus = 1'b1;
            end
            RD_SETUP, RD_WAIT_S: begin
                enableOutput = 1'b1;
            end
            default: begin
                wr           = 1'b1;
                enableOutput = 1'b0;
                drive_bus    = 1'b0;
            end
        endcase
    end

    // Request capture, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            write_last_reg <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (accept) begin
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                if (req_we) begin
                    write_last_reg <= 1'b1;
                end
            end
            if (state_reg == TURN) begin
                write_last_reg <= 1'b0;
            end
            if (state_reg == RD_SETUP) begin
                cnt_reg <= CNT_W'(RD_WAIT - 1);
            end else if (state_reg == RD_WAIT_S) begin
                if (cnt_reg == '0) begin
                    // Last wait cycle: the SRAM has had its full access time.
                    rsp_valid_reg <= 1'b1;
                    rsp_rdata_reg <= mainBus;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
        end
    end

    assign mainBusAddr = addr_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;

    // Per-bit tristate driver; only the write states own the bus.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bus_drv
            assign mainBus[gi] = drive_bus ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

endmodule
